// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle between the requesting core ports and the shared slave bus.
// The arbiter sits on the master side; the cores and the slave decode sit on the slave side.
interface mem_bus_arbiter_if #(
    parameter int N_PORTS   = 4,
    parameter int PORT_BITS = 2
);
    logic [N_PORTS-1:0]    port_valid;
    logic [32*N_PORTS-1:0] port_addr;
    logic [32*N_PORTS-1:0] port_wdata;
    logic [4*N_PORTS-1:0]  port_wstrb;
    logic [N_PORTS-1:0]    port_ready;
    logic [32*N_PORTS-1:0] port_rdata;

    logic                  bus_valid;
    logic [31:0]           bus_addr;
    logic [31:0]           bus_wdata;
    logic [3:0]            bus_wstrb;
    logic [PORT_BITS-1:0]  bus_port;
    logic                  bus_ready;
    logic [31:0]           bus_rdata;
    logic                  bus_error;

    modport master (
        input  port_valid, port_addr, port_wdata, port_wstrb,
        input  bus_ready, bus_rdata,
        output port_ready, port_rdata,
        output bus_valid, bus_addr, bus_wdata, bus_wstrb, bus_port, bus_error
    );

    modport slave (
        output port_valid, port_addr, port_wdata, port_wstrb,
        output bus_ready, bus_rdata,
        input  port_ready, port_rdata,
        input  bus_valid, bus_addr, bus_wdata, bus_wstrb, bus_port, bus_error
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// N-port arbiter from picorv32 native memory ports onto one shared slave bus,
// round-robin or fixed priority, with a bus timeout that completes with an error word.
//
// state | meaning
// IDLE  | no transaction; arbitrate among port_valid and launch the winner
// REQ   | bus_valid held with the granted request; wait for bus_ready or timeout
// DONE  | port_ready (and bus_error on timeout) pulse; no arbitration this cycle
module mem_bus_arbiter #(
    parameter int          N_PORTS   = 4,
    parameter int          ARB_MODE  = 0,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master bif
);
    localparam int PORT_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int SCAN_W    = PORT_BITS + 1;
    localparam int TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TMR_W-1:0]     TMR_LOAD = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
    localparam logic [PORT_BITS-1:0] LAST_RST = PORT_BITS'(N_PORTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [PORT_BITS-1:0]  last_q,      last_d;
    logic [PORT_BITS-1:0]  port_q,      port_d;
    logic                  bus_valid_q, bus_valid_d;
    logic [31:0]           bus_addr_q,  bus_addr_d;
    logic [31:0]           bus_wdata_q, bus_wdata_d;
    logic [3:0]            bus_wstrb_q, bus_wstrb_d;
    logic [N_PORTS-1:0]    port_ready_q, port_ready_d;
    logic [32*N_PORTS-1:0] port_rdata_q, port_rdata_d;
    logic                  bus_error_q, bus_error_d;
    logic [TMR_W-1:0]      tmr_q,       tmr_d;

    logic                  gnt_found;
    logic [PORT_BITS-1:0]  gnt_idx;
    logic [SCAN_W-1:0]     scan;

    // Loops run from the lowest-priority candidate upward so the last hit is the winner.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        if (ARB_MODE == 1) begin
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                if (bif.port_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PORT_BITS'(i);
                end
            end
        end else begin
            for (int i = N_PORTS; i >= 1; i--) begin
                scan = {1'b0, last_q} + SCAN_W'(i);
                if (scan >= SCAN_W'(N_PORTS)) begin
                    scan = scan - SCAN_W'(N_PORTS);
                end
                if (bif.port_valid[scan[PORT_BITS-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = scan[PORT_BITS-1:0];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        port_d       = port_q;
        bus_valid_d  = bus_valid_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        port_rdata_d = port_rdata_q;
        tmr_d        = tmr_q;
        port_ready_d = '0;
        bus_error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    port_d      = gnt_idx;
                    last_d      = gnt_idx;
                    bus_addr_d  = bif.port_addr[32*gnt_idx +: 32];
                    bus_wdata_d = bif.port_wdata[32*gnt_idx +: 32];
                    bus_wstrb_d = bif.port_wstrb[4*gnt_idx +: 4];
                    bus_valid_d = 1'b1;
                    tmr_d       = TMR_LOAD;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bif.bus_ready) begin
                    bus_valid_d                   = 1'b0;
                    port_rdata_d[32*port_q +: 32] = bif.bus_rdata;
                    port_ready_d[port_q]          = 1'b1;
                    state_d                       = DONE;
                end else if ((TIMEOUT > 0) && (tmr_q == '0)) begin
                    bus_valid_d                   = 1'b0;
                    port_rdata_d[32*port_q +: 32] = ERR_RDATA;
                    port_ready_d[port_q]          = 1'b1;
                    bus_error_d                   = 1'b1;
                    state_d                       = DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= LAST_RST;
            port_q       <= '0;
            bus_valid_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            port_ready_q <= '0;
            port_rdata_q <= '0;
            bus_error_q  <= 1'b0;
            tmr_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            port_q       <= port_d;
            bus_valid_q  <= bus_valid_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            port_ready_q <= port_ready_d;
            port_rdata_q <= port_rdata_d;
            bus_error_q  <= bus_error_d;
            tmr_q        <= tmr_d;
        end
    end

    assign bif.bus_valid  = bus_valid_q;
    assign bif.bus_addr   = bus_addr_q;
    assign bif.bus_wdata  = bus_wdata_q;
    assign bif.bus_wstrb  = bus_wstrb_q;
    assign bif.bus_port   = port_q;
    assign bif.port_ready = port_ready_q;
    assign bif.port_rdata = port_rdata_q;
    assign bif.bus_error  = bus_error_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin instance with TIMEOUT=8 tracked by a
// transaction-level model every cycle, and a fixed-priority instance with no timeout.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   tests = 0;
    int   fails = 0;

    mem_bus_arbiter_if #(.N_PORTS(4), .PORT_BITS(2)) if_a ();
    mem_bus_arbiter_if #(.N_PORTS(4), .PORT_BITS(2)) if_b ();

    mem_bus_arbiter #(.N_PORTS(4), .ARB_MODE(0), .TIMEOUT(8), .ERR_RDATA(32'hDEADBEEF))
        dut_a (.clk(clk), .reset(rst_a), .bif(if_a));
    mem_bus_arbiter #(.N_PORTS(4), .ARB_MODE(1), .TIMEOUT(0), .ERR_RDATA(32'hDEADBEEF))
        dut_b (.clk(clk), .reset(rst_b), .bif(if_b));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Slave A: acks after sa_delay extra cycles of bus_valid (-1 = never); sa_force pulses bus_ready.
    int          sa_delay = 0;
    int          sa_cnt   = 0;
    logic [31:0] sa_data  = 32'h0;
    bit          sa_force = 1'b0;
    always @(posedge clk) begin
        #2;
        if (sa_force) begin
            if_a.bus_ready = 1'b1;
            if_a.bus_rdata = 32'hBAD0BAD0;
        end else if (if_a.bus_valid) begin
            if (sa_delay >= 0 && sa_cnt == sa_delay) begin
                if_a.bus_ready = 1'b1;
                if_a.bus_rdata = sa_data;
            end else begin
                if_a.bus_ready = 1'b0;
            end
            sa_cnt++;
        end else begin
            sa_cnt         = 0;
            if_a.bus_ready = 1'b0;
        end
    end

    bit sb_stall = 1'b0;
    always @(posedge clk) begin
        #2;
        if_b.bus_ready = if_b.bus_valid & ~sb_stall;
        if_b.bus_rdata = 32'hB0B00000 | {30'b0, if_b.bus_port};
    end

    // Transaction-level expectation for dut_a: phase 0 waiting for work, 1 on the bus, 2 completing.
    int           m_phase, m_wait, m_g, m_last;
    logic         e_bv, e_err;
    logic [31:0]  e_addr, e_wdata;
    logic [3:0]   e_wstrb, e_rdy;
    logic [1:0]   e_port;
    logic [127:0] e_rdata;

    task automatic model_finish(input logic [31:0] data, input logic err);
        e_bv                   = 1'b0;
        e_rdata[32*m_g +: 32]  = data;
        e_rdy[m_g]             = 1'b1;
        e_err                  = err;
        m_phase                = 2;
    endtask

    task automatic model_step();
        int idx;
        if (rst_a) begin
            m_phase = 0; m_wait = 0; m_g = 0; m_last = 3;
            e_bv = 0; e_err = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
            e_rdy = 0; e_port = 0; e_rdata = 0;
        end else begin
            e_rdy = 0;
            e_err = 0;
            if (m_phase == 0) begin
                m_g = -1;
                for (int k = 1; k <= 4; k++) begin
                    idx = (m_last + k) % 4;
                    if (m_g < 0 && if_a.port_valid[idx[1:0]]) m_g = idx;
                end
                if (m_g >= 0) begin
                    e_port  = m_g[1:0];
                    e_addr  = if_a.port_addr[32*m_g +: 32];
                    e_wdata = if_a.port_wdata[32*m_g +: 32];
                    e_wstrb = if_a.port_wstrb[4*m_g +: 4];
                    e_bv    = 1'b1;
                    m_last  = m_g;
                    m_wait  = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (if_a.bus_ready) begin
                    model_finish(if_a.bus_rdata, 1'b0);
                end else begin
                    m_wait++;
                    if (m_wait == 8) model_finish(32'hDEADBEEF, 1'b1);
                end
            end else begin
                m_phase = 0;
            end
        end
    endtask

    int   cyc = 0;
    int   grants_a[$];
    int   rdy_cyc[$];
    logic prev_bv = 1'b0;
    always @(posedge clk) begin
        model_step();
        #1;
        cyc++;
        chk("bus_valid",  if_a.bus_valid,  e_bv);
        chk("bus_addr",   if_a.bus_addr,   e_addr);
        chk("bus_wdata",  if_a.bus_wdata,  e_wdata);
        chk("bus_wstrb",  if_a.bus_wstrb,  e_wstrb);
        chk("bus_port",   if_a.bus_port,   e_port);
        chk("port_ready", if_a.port_ready, e_rdy);
        chk("port_rdata", if_a.port_rdata, e_rdata);
        chk("bus_error",  if_a.bus_error,  e_err);
        if (if_a.bus_valid && !prev_bv) grants_a.push_back(int'(if_a.bus_port));
        if (|if_a.port_ready) rdy_cyc.push_back(cyc);
        prev_bv = if_a.bus_valid;
    end

    task automatic wait_rdy_a(input int p, input int max, output int nbv, output bit ok);
        nbv = 0;
        ok  = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (if_a.bus_valid) nbv++;
            if (if_a.port_ready[p]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_ready_a", ok, 1'b1);
    endtask

    task automatic wait_bv_a(input int max);
        bit ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (if_a.bus_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_bus_valid_a", ok, 1'b1);
    endtask

    task automatic wait_rdy_b(input int max, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < max; n++) begin
            @(negedge clk);
            if (|if_b.port_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_ready_b", ok, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbv;
        bit ok;
        bit seen;
        int exp_order[8];
        exp_order = '{3, 0, 1, 2, 3, 0, 1, 2};

        rst_a = 1'b1; rst_b = 1'b1;
        if_a.port_valid = '0; if_a.port_addr = '0; if_a.port_wdata = '0; if_a.port_wstrb = '0;
        if_b.port_valid = '0; if_b.port_addr = '0; if_b.port_wdata = '0; if_b.port_wstrb = '0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        chk("reset_bus_valid",  if_a.bus_valid,  1'b0);
        chk("reset_port_ready", if_a.port_ready, 4'b0);
        chk("reset_port_rdata", if_a.port_rdata, 128'h0);
        chk("reset_bus_port",   if_a.bus_port,   2'd0);

        // Read on port 2, slave acks on the third bus_valid cycle.
        @(negedge clk);
        if_a.port_addr[95:64] = 32'h0000_0040;
        if_a.port_valid       = 4'b0100;
        sa_delay = 2; sa_data = 32'h12345678;
        wait_rdy_a(2, 20, nbv, ok);
        chk("t1_bus_port",   if_a.bus_port,          2'd2);
        chk("t1_port_ready", if_a.port_ready,        4'b0100);
        chk("t1_rdata2",     if_a.port_rdata[95:64], 32'h12345678);
        chk("t1_bv_cycles",  nbv,                    3);
        if_a.port_valid = 4'b0000;
        @(negedge clk);
        chk("t1_ready_pulse", if_a.port_ready, 4'b0);

        // All four ports continuously requesting with a zero-wait slave.
        if_a.port_addr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
        sa_delay = 0; sa_data = 32'h0000_1111;
        grants_a.delete();
        rdy_cyc.delete();
        if_a.port_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            bit got = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (|if_a.port_ready) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("t2_completion", got, 1'b1);
        end
        if_a.port_valid = 4'b0000;
        chk("t2_grant_count", grants_a.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < grants_a.size(); i++) chk("t2_grant_order", grants_a[i], exp_order[i]);
        for (int i = 0; i + 1 < 8 && i + 1 < rdy_cyc.size(); i++) chk("t2_spacing", rdy_cyc[i+1] - rdy_cyc[i], 3);
        repeat (2) @(negedge clk);

        // Timeout: slave never acks, then acks exactly on the eighth cycle.
        if_a.port_addr[31:0] = 32'h0000_0100;
        if_a.port_valid      = 4'b0001;
        sa_delay = -1;
        wait_rdy_a(0, 40, nbv, ok);
        chk("t4_bv_cycles", nbv,                   8);
        chk("t4_bus_error", if_a.bus_error,        1'b1);
        chk("t4_rdata0",    if_a.port_rdata[31:0], 32'hDEADBEEF);
        if_a.port_valid = 4'b0000;
        @(negedge clk);
        chk("t4_error_pulse", if_a.bus_error, 1'b0);
        if_a.port_valid = 4'b0001;
        sa_delay = 7; sa_data = 32'h0C0FFEE0;
        wait_rdy_a(0, 40, nbv, ok);
        chk("t4b_bv_cycles", nbv,                   8);
        chk("t4b_bus_error", if_a.bus_error,        1'b0);
        chk("t4b_rdata0",    if_a.port_rdata[31:0], 32'h0C0FFEE0);
        if_a.port_valid = 4'b0000;
        repeat (2) @(negedge clk);

        // Reset while port 2 sits in REQ; a stray bus_ready afterwards must be ignored.
        if_a.port_valid = 4'b0100;
        sa_delay = -1;
        wait_bv_a(10);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        if_a.port_valid = 4'b0000;
        @(negedge clk);
        rst_a = 1'b0;
        chk("t5_bus_valid",  if_a.bus_valid,  1'b0);
        chk("t5_port_ready", if_a.port_ready, 4'b0);
        chk("t5_bus_error",  if_a.bus_error,  1'b0);
        sa_force = 1'b1;
        @(negedge clk);
        sa_force = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t5_stray_ready", {if_a.bus_valid, if_a.port_ready, if_a.bus_error}, 6'b0);
        end
        if_a.port_valid = 4'b1001;
        sa_delay = 0; sa_data = 32'h55AA55AA;
        wait_rdy_a(0, 10, nbv, ok);
        chk("t5_first_grant", if_a.port_ready, 4'b0001);
        chk("t5_bus_port",    if_a.bus_port,   2'd0);
        if_a.port_valid = 4'b1000;
        wait_rdy_a(3, 10, nbv, ok);
        chk("t5_second_grant", if_a.bus_port, 2'd3);
        if_a.port_valid = 4'b0000;
        repeat (2) @(negedge clk);

        // Write on port 1 is forwarded verbatim; other ports' read data stay put.
        if_a.port_addr[63:32]  = 32'h2000_0008;
        if_a.port_wdata[63:32] = 32'hAABBCCDD;
        if_a.port_wstrb[7:4]   = 4'b0100;
        if_a.port_valid        = 4'b0010;
        sa_delay = 1; sa_data = 32'h11110000;
        wait_bv_a(10);
        chk("t6_bus_addr",  if_a.bus_addr,  32'h2000_0008);
        chk("t6_bus_wdata", if_a.bus_wdata, 32'hAABBCCDD);
        chk("t6_bus_wstrb", if_a.bus_wstrb, 4'b0100);
        chk("t6_bus_port",  if_a.bus_port,  2'd1);
        wait_rdy_a(1, 10, nbv, ok);
        chk("t6_rdata", if_a.port_rdata, {32'h55AA55AA, 32'h0, 32'h11110000, 32'h55AA55AA});
        if_a.port_valid = 4'b0000;
        repeat (2) @(negedge clk);

        // Fixed priority: port 0 wins while it keeps requesting; port 3 follows right after it drops.
        if_b.port_valid = 4'b1001;
        for (int t = 0; t < 4; t++) begin
            wait_rdy_b(10, ok);
            chk("t3_port0_wins", if_b.port_ready, 4'b0001);
        end
        if_b.port_valid = 4'b1000;
        @(negedge clk);
        chk("t3_idle_gap", if_b.bus_valid, 1'b0);
        @(negedge clk);
        chk("t3_port3_bv",   if_b.bus_valid, 1'b1);
        chk("t3_port3_port", if_b.bus_port,  2'd3);
        wait_rdy_b(10, ok);
        chk("t3_port3_ready", if_b.port_ready, 4'b1000);
        chk("t3_port3_rdata", if_b.port_rdata[127:96], 32'hB0B00003);
        if_b.port_valid = 4'b0000;
        repeat (2) @(negedge clk);

        // TIMEOUT=0 never gives up on a stalled slave.
        sb_stall = 1'b1;
        if_b.port_valid = 4'b0100;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if ((|if_b.port_ready) || if_b.bus_error) seen = 1'b1;
        end
        chk("t7_no_timeout_bv",   if_b.bus_valid, 1'b1);
        chk("t7_no_timeout_done", seen,           1'b0);
        sb_stall = 1'b0;
        wait_rdy_b(10, ok);
        chk("t7_late_ready", if_b.port_ready, 4'b0100);
        chk("t7_no_error",   if_b.bus_error,  1'b0);
        if_b.port_valid = 4'b0000;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
